sht10_convert: RTL



---
 rtl/sht10_defs_pkg.sv | 44 ++++
 rtl/sht10_shift_mult.sv | 65 ++++++
 rtl/sht10_convert.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sht10_defs_pkg.sv
// Shared definitions for the SHT10 conversion stage:
// state encodings, RH Q24 coefficients, datapath widths.
package sht10_defs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TEMP,
      MUL_C2,
      MUL_C3,
      MUL_SQ,
      SUM,
      BCD,
      DONE
   } state_e;

   localparam int RAW_W    = 14;
   localparam int SO_W     = 12;
   localparam int PROD_W   = 36;
   localparam int BCD_W    = 20;
   localparam int MAG_W    = 16;
   localparam int ACC_W    = 37;
   localparam int RH_SHIFT = 24;

   localparam logic [PROD_W-1:0] C2 = 36'd6157238;
   localparam logic [PROD_W-1:0] C3 = 36'd268;
   localparam logic signed [ACC_W-1:0] C1 = 37'sd343396057;
   localparam logic signed [ACC_W-1:0] RH_MAX = 37'sd1000;

   // One double-dabble iteration: adjust digits >= 5, then shift in one bit.
   function automatic logic [BCD_W+MAG_W-1:0] dabble_step(
      input logic [BCD_W-1:0] bcd,
      input logic [MAG_W-1:0] bin
   );
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      return {adj, bin} << 1;
   endfunction

endpackage

// File: rtl/sht10_shift_mult.sv
// Unsigned 36x12 shift-add multiplier, one multiplier bit per cycle.
// The product is presented combinationally in the cycle done is high.
module sht10_shift_mult
   import sht10_defs_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [PROD_W-1:0] a,
   input  logic [SO_W-1:0]   b,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] acc_q, acc_d;
   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [SO_W-1:0]   mplier_q, mplier_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              run_q, run_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      done     = 1'b0;
      if (start) begin
         // first iteration works straight from the operand ports
         acc_d    = b[0] ? a : '0;
         mcand_d  = a << 1;
         mplier_d = b >> 1;
         cnt_d    = 4'd1;
         run_d    = 1'b1;
      end else if (run_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 4'd1;
         if (cnt_q == 4'(SO_W - 1)) begin
            done  = 1'b1;
            run_d = 1'b0;
         end
      end
   end

   assign product = acc_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/sht10_convert.sv
// Raw SHT10 temperature/RH word to signed deci-unit BCD digits.
// One conversion in flight; RH products share one shift-add multiplier.
module sht10_convert
   import sht10_defs_pkg::*;
#(
   parameter int D1_CENTI = -3960
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             raw_valid,
   input  logic             raw_sel,
   input  logic [RAW_W-1:0] raw_data,
   output logic             raw_ready,
   output logic             busy,
   output logic             bcd_valid,
   output logic             bcd_sel,
   output logic             bcd_neg,
   output logic [15:0]      bcd_digits,
   output logic             out_of_range
);

   state_e state_q, state_d;
   logic [RAW_W-1:0] raw_q, raw_d;
   logic sel_q, sel_d, start_q, start_d;
   logic [PROD_W-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic neg_q, neg_d, oor_pend_q, oor_pend_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0] cnt_q, cnt_d;
   logic valid_q, valid_d, out_sel_q, out_sel_d;
   logic out_neg_q, out_neg_d, oor_q, oor_d;
   logic [15:0] dig_q, dig_d, dig_sel;
   logic [PROD_W-1:0] mul_a, mul_p;
   logic mul_done;
   logic signed [MAG_W-1:0] t;
   logic signed [ACC_W-1:0] acc, rh;
   logic [BCD_W+MAG_W-1:0] step;

   sht10_shift_mult u_mult (
      .clock   (clock),
      .reset   (reset),
      .start   (start_q),
      .a       (mul_a),
      .b       (raw_q[SO_W-1:0]),
      .done    (mul_done),
      .product (mul_p)
   );

   always_comb begin
      state_d    = state_q;
      raw_d      = raw_q;
      sel_d      = sel_q;
      start_d    = 1'b0;
      p1_d       = p1_q;
      p2_d       = p2_q;
      p3_d       = p3_q;
      mag_d      = mag_q;
      neg_d      = neg_q;
      oor_pend_d = oor_pend_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      out_sel_d  = out_sel_q;
      out_neg_d  = out_neg_q;
      oor_d      = oor_q;
      dig_d      = dig_q;
      mul_a      = '0;
      t    = $signed({2'b00, raw_q}) + 16'(D1_CENTI);
      acc  = $signed({1'b0, p1_q}) - $signed({1'b0, p3_q}) - C1;
      rh   = acc >>> RH_SHIFT;
      step = dabble_step(bcd_q, mag_q);
      // temperature drops the hundredths digit; RH is already deci
      dig_sel = sel_q ? step[31:16] : step[35:20];
      unique case (state_q)
         IDLE: begin
            if (raw_valid) begin
               raw_d = raw_data;
               sel_d = raw_sel;
               if (raw_sel) begin
                  state_d = MUL_C2;
                  start_d = 1'b1;
               end else begin
                  state_d = TEMP;
               end
            end
         end
         TEMP: begin
            mag_d   = t[MAG_W-1] ? -t : t;
            neg_d   = t[MAG_W-1];
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = BCD;
         end
         MUL_C2: begin
            mul_a = C2;
            if (mul_done) begin
               p1_d    = mul_p;
               start_d = 1'b1;
               state_d = MUL_C3;
            end
         end
         MUL_C3: begin
            mul_a = C3;
            if (mul_done) begin
               p2_d    = mul_p;
               start_d = 1'b1;
               state_d = MUL_SQ;
            end
         end
         MUL_SQ: begin
            mul_a = p2_q;
            if (mul_done) begin
               p3_d    = mul_p;
               state_d = SUM;
            end
         end
         SUM: begin
            if (rh < 0) begin
               mag_d      = '0;
               oor_pend_d = 1'b1;
            end else if (rh > RH_MAX) begin
               mag_d      = RH_MAX[MAG_W-1:0];
               oor_pend_d = 1'b1;
            end else begin
               mag_d      = rh[MAG_W-1:0];
               oor_pend_d = 1'b0;
            end
            neg_d   = 1'b0;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = BCD;
         end
         BCD: begin
            bcd_d = step[BCD_W+MAG_W-1:MAG_W];
            mag_d = step[MAG_W-1:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               dig_d     = dig_sel;
               out_neg_d = neg_q && (dig_sel != 16'd0);
               out_sel_d = sel_q;
               if (sel_q) begin
                  oor_d = oor_pend_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         raw_q      <= '0;
         sel_q      <= 1'b0;
         start_q    <= 1'b0;
         p1_q       <= '0;
         p2_q       <= '0;
         p3_q       <= '0;
         mag_q      <= '0;
         neg_q      <= 1'b0;
         oor_pend_q <= 1'b0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         out_sel_q  <= 1'b0;
         out_neg_q  <= 1'b0;
         oor_q      <= 1'b0;
         dig_q      <= '0;
      end else begin
         state_q    <= state_d;
         raw_q      <= raw_d;
         sel_q      <= sel_d;
         start_q    <= start_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         p3_q       <= p3_d;
         mag_q      <= mag_d;
         neg_q      <= neg_d;
         oor_pend_q <= oor_pend_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         out_sel_q  <= out_sel_d;
         out_neg_q  <= out_neg_d;
         oor_q      <= oor_d;
         dig_q      <= dig_d;
      end
   end

   assign raw_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign bcd_valid    = valid_q;
   assign bcd_sel      = out_sel_q;
   assign bcd_neg      = out_neg_q;
   assign bcd_digits   = dig_q;
   assign out_of_range = oor_q;

endmodule
